// File: rtl/hamming_enc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hamming_enc_arbiter
// Description : Round-robin arbiter in front of a shared (16,11) SECDED encoder
//               that feeds a 2-entry valid/ready output FIFO.
//               Optional feature macro: HAM_ERR_INJECT_EN (one-shot bit flip).
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_enc_arbiter #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [11*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic [CNT_W-1:0]     cw_count
`ifdef HAM_ERR_INJECT_EN
  ,
  input  logic                 inj_arm,
  input  logic [3:0]           inj_bit
`endif
);

  localparam logic [SRC_W-1:0] c_PTR_RST = SRC_W'(N_REQ - 1);
  localparam logic [SRC_W:0]   c_N_REQ   = (SRC_W + 1)'(N_REQ);

  // Codeword layout: {d[10:0], p0, p1, p2, p3, p4}
  function automatic logic [15:0] f_encode(input logic [10:0] d);
    logic p0, p1, p2, p3, p4;
    p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
    p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
    p3 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    p4 = ^d[10:4];
    p0 = (^d) ^ p1 ^ p2 ^ p3 ^ p4;
    return {d, p0, p1, p2, p3, p4};
  endfunction

  logic [SRC_W-1:0] r_ptr;
  logic             r_head_vld;
  logic [15:0]      r_head_data;
  logic [SRC_W-1:0] r_head_src;
  logic             r_tail_vld;
  logic [15:0]      r_tail_data;
  logic [SRC_W-1:0] r_tail_src;
  logic [CNT_W-1:0] r_cw_count;

  logic             w_found;
  logic [SRC_W-1:0] w_grant;
  logic [SRC_W:0]   w_idx;
  logic             w_space;
  logic             w_push;
  logic             w_pop;
  logic [10:0]      w_word;
  logic [15:0]      w_inj_mask;
  logic [15:0]      w_push_cw;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (SRC_W + 1)'(i);
      if (w_idx >= c_N_REQ) begin
        w_idx = w_idx - c_N_REQ;
      end
      if (!w_found && req_valid[w_idx[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[SRC_W-1:0];
      end
    end
  end

  // Space is judged from registered occupancy only, never from out_ready.
  assign w_space = !(r_head_vld && r_tail_vld);
  assign w_push  = w_found && w_space;
  assign w_pop   = r_head_vld && out_ready;

  always_comb begin
    req_ready = '0;
    if (w_push) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_word    = req_data[11*w_grant +: 11];
  assign w_push_cw = f_encode(w_word) ^ w_inj_mask;

`ifdef HAM_ERR_INJECT_EN
  logic       r_inj_armed;
  logic [3:0] r_inj_bit;
  logic       w_inj_live;
  logic [3:0] w_inj_sel;

  // An arm coinciding with a push takes effect on that same push.
  assign w_inj_live = inj_arm || r_inj_armed;
  assign w_inj_sel  = inj_arm ? inj_bit : r_inj_bit;
  assign w_inj_mask = w_inj_live ? (16'h0001 << w_inj_sel) : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj_armed <= 1'b0;
      r_inj_bit   <= 4'd0;
    end else if (w_push && w_inj_live) begin
      r_inj_armed <= 1'b0;
    end else if (inj_arm) begin
      r_inj_armed <= 1'b1;
      r_inj_bit   <= inj_bit;
    end
  end
`else
  assign w_inj_mask = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= c_PTR_RST;
    end else if (w_push) begin
      r_ptr <= w_grant;
    end
  end

  // Head register drives the outputs directly so they hold when emptied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_vld  <= 1'b0;
      r_head_data <= '0;
      r_head_src  <= '0;
      r_tail_vld  <= 1'b0;
      r_tail_data <= '0;
      r_tail_src  <= '0;
    end else if (w_pop) begin
      if (r_tail_vld) begin
        r_head_vld  <= 1'b1;
        r_head_data <= r_tail_data;
        r_head_src  <= r_tail_src;
        r_tail_vld  <= w_push;
        if (w_push) begin
          r_tail_data <= w_push_cw;
          r_tail_src  <= w_grant;
        end
      end else begin
        r_head_vld <= w_push;
        if (w_push) begin
          r_head_data <= w_push_cw;
          r_head_src  <= w_grant;
        end
      end
    end else if (w_push) begin
      if (r_head_vld) begin
        r_tail_vld  <= 1'b1;
        r_tail_data <= w_push_cw;
        r_tail_src  <= w_grant;
      end else begin
        r_head_vld  <= 1'b1;
        r_head_data <= w_push_cw;
        r_head_src  <= w_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw_count <= '0;
    end else if (w_pop && (r_cw_count != {CNT_W{1'b1}})) begin
      r_cw_count <= r_cw_count + 1'b1;
    end
  end

  assign out_valid = r_head_vld;
  assign out_data  = r_head_data;
  assign out_src   = r_head_src;
  assign cw_count  = r_cw_count;

endmodule
`default_nettype wire
